luma_line_buffer: RTL and testbench

//  Sits directly downstream of the contrast/brightness stage. Converts each

---
 rtl/luma_line_buffer_if.sv | 25 ++
 rtl/luma_line_buffer.sv | 147 ++++++++++++++
 tb/tb_luma_line_buffer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/luma_line_buffer_if.sv
// Pixel-in / column-out bundle between the contrast stage, the luma line
// buffer and the Sobel window stage.
interface luma_line_buffer_if #(
  parameter int XW = 10
);
  logic          sof;
  logic          pix_valid;
  logic [23:0]   pix_rgb;
  logic          col_valid;
  logic [7:0]    col_top;
  logic [7:0]    col_mid;
  logic [7:0]    col_bot;
  logic [XW-1:0] col_x;
  logic [XW-1:0] col_y;

  modport master (
    output sof, pix_valid, pix_rgb,
    input  col_valid, col_top, col_mid, col_bot, col_x, col_y
  );

  modport slave (
    input  sof, pix_valid, pix_rgb,
    output col_valid, col_top, col_mid, col_bot, col_x, col_y
  );
endinterface

// File: rtl/luma_line_buffer.sv
// RGB -> luma conversion with two line RAMs; emits a 3-row vertical luma
// column (y-2, y-1, y) per pixel from line 2 onward, 2 clocks after the pixel.
//
// state    | meaning
// S_IDLE   | waiting for a pixel qualified by sof
// S_FILL0  | line 0 being written into the line RAMs
// S_FILL1  | line 1 being written into the line RAMs
// S_STREAM | lines 2.. : one column per accepted pixel
module luma_line_buffer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10
) (
  input  logic                clk,
  input  logic                reset,
  luma_line_buffer_if.slave   bus
);

  localparam int            AW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] Y_LAST = XW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] ONE    = XW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL0, S_FILL1, S_STREAM} state_t;

  state_t        r_state, w_state_nxt, w_st;
  logic [XW-1:0] r_x, r_y, w_x_nxt, w_y_nxt, w_px, w_py;
  logic          w_acc, w_emit, w_eol;
  logic [15:0]   w_luma_sum;
  logic [7:0]    w_luma;

  logic          r_v1, r_emit1;
  logic [XW-1:0] r_x1, r_y1;
  logic [7:0]    r_luma, r_lb0_rd, r_lb1_rd;
  logic [7:0]    r_lb0 [H_ACTIVE];
  logic [7:0]    r_lb1 [H_ACTIVE];

  logic          r_col_valid;
  logic [7:0]    r_col_top, r_col_mid, r_col_bot;
  logic [XW-1:0] r_col_x, r_col_y;

  // A sof pixel restarts the frame from any state and is position (0,0).
  assign w_acc  = bus.pix_valid & (bus.sof | (r_state != S_IDLE));
  assign w_emit = bus.pix_valid & ~bus.sof & (r_state == S_STREAM);
  assign w_px   = bus.sof ? '0 : r_x;
  assign w_py   = bus.sof ? '0 : r_y;
  assign w_eol  = (w_px == X_LAST);

  assign w_luma_sum = 16'd77  * {8'd0, bus.pix_rgb[23:16]}
                    + 16'd150 * {8'd0, bus.pix_rgb[15:8]}
                    + 16'd29  * {8'd0, bus.pix_rgb[7:0]};
  assign w_luma     = 8'(w_luma_sum >> 8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_st        = bus.sof ? S_FILL0 : r_state;
    if (w_acc) begin
      w_state_nxt = w_st;
      if (w_eol) begin
        w_x_nxt = '0;
        w_y_nxt = (w_py == Y_LAST) ? '0 : w_py + ONE;
        case (w_st)
          S_FILL0:  w_state_nxt = S_FILL1;
          S_FILL1:  w_state_nxt = S_STREAM;
          S_STREAM: if (w_py == Y_LAST) w_state_nxt = S_IDLE;
          default:  w_state_nxt = w_st;
        endcase
      end else begin
        w_x_nxt = w_px + ONE;
        w_y_nxt = w_py;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1    <= 1'b0;
      r_emit1 <= 1'b0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_luma  <= '0;
    end else begin
      r_v1    <= w_acc;
      r_emit1 <= w_emit;
      if (w_acc) begin
        r_x1   <= w_px;
        r_y1   <= w_py;
        r_luma <= w_luma;
      end
    end
  end

  // Read at acceptance, write back one cycle later once luma is registered;
  // lb1 takes the old lb0 word, so the shift is read-before-write per column.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0_rd <= r_lb0[w_px[AW-1:0]];
      r_lb1_rd <= r_lb1[w_px[AW-1:0]];
    end
    if (r_v1) begin
      r_lb0[r_x1[AW-1:0]] <= r_luma;
      r_lb1[r_x1[AW-1:0]] <= r_lb0_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col_valid <= 1'b0;
      r_col_top   <= '0;
      r_col_mid   <= '0;
      r_col_bot   <= '0;
      r_col_x     <= '0;
      r_col_y     <= '0;
    end else begin
      r_col_valid <= r_emit1;
      if (r_emit1) begin
        r_col_top <= r_lb1_rd;
        r_col_mid <= r_lb0_rd;
        r_col_bot <= r_luma;
        r_col_x   <= r_x1;
        r_col_y   <= r_y1 - ONE;
      end
    end
  end

  assign bus.col_valid = r_col_valid;
  assign bus.col_top   = r_col_top;
  assign bus.col_mid   = r_col_mid;
  assign bus.col_bot   = r_col_bot;
  assign bus.col_x     = r_col_x;
  assign bus.col_y     = r_col_y;

endmodule

// File: tb/tb_luma_line_buffer.sv
// Directed bench for luma_line_buffer on an 8x4 frame; expected columns are
// queued when pixels are driven and popped when col_valid is seen.
module tb_luma_line_buffer;

  localparam int H = 8;
  localparam int V = 4;

  typedef struct {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
    logic [9:0] x;
    logic [9:0] y;
    int         due;
  } col_t;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;
  int   col_cnt;
  col_t sb[$];
  logic [7:0] img [V][H];

  luma_line_buffer_if #(.XW(10)) bus ();

  luma_line_buffer #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_luma(input logic [23:0] p);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
    return 8'(s >> 8);
  endfunction

  // Mode 0: gray line n = 10*n. Mode 1: known colours on line 2, random elsewhere.
  function automatic logic [23:0] pix_of(input int mode, input int x, input int y);
    logic [7:0] v;
    if (mode == 0) begin
      v = 8'(10 * y);
      return {v, v, v};
    end
    if (y == 2 && x < 4) begin
      case (x)
        0:       return 24'hFF0000;
        1:       return 24'h00FF00;
        2:       return 24'hFFFFFF;
        default: return 24'h000000;
      endcase
    end
    return 24'($urandom);
  endfunction

  function automatic logic [7:0] exp_lum(input int mode, input int x, input int y,
                                         input logic [23:0] p);
    if (mode == 0) return 8'(10 * y);
    if (y == 2 && x < 4) begin
      case (x)
        0:       return 8'd76;
        1:       return 8'd149;
        2:       return 8'd255;
        default: return 8'd0;
      endcase
    end
    return ref_luma(p);
  endfunction

  task automatic idle();
    @(negedge clk);
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
  endtask

  task automatic drive(input logic s, input logic [23:0] p, input bit exp_col, input col_t e);
    col_t q;
    @(negedge clk);
    bus.sof       = s;
    bus.pix_valid = 1'b1;
    bus.pix_rgb   = p;
    if (exp_col) begin
      q     = e;
      q.due = cyc + 2;
      sb.push_back(q);
    end
  endtask

  task automatic run_frame(input int mode, input int npix, input int gap_pct, input bit tail_idle);
    logic [23:0] p;
    logic [7:0]  l;
    col_t        e;
    for (int i = 0; i < npix; i++) begin
      int x;
      int y;
      x = i % H;
      y = i / H;
      if (gap_pct > 0 && i > 0 && $urandom_range(99) < gap_pct) idle();
      p = pix_of(mode, x, y);
      l = exp_lum(mode, x, y, p);
      img[y][x] = l;
      e = '{top: 8'd0, mid: 8'd0, bot: l, x: 10'(x), y: 10'(y - 1), due: 0};
      if (y >= 2) begin
        e.top = img[y-2][x];
        e.mid = img[y-1][x];
      end
      drive(i == 0, p, y >= 2, e);
    end
    if (tail_idle) idle();
  endtask

  task automatic drain();
    repeat (4) idle();
    chk("sb_empty", 32'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (bus.col_valid === 1'b1) begin
      col_t e;
      col_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_col", 32'(bus.col_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("col_top", 32'(bus.col_top), 32'(e.top));
        chk("col_mid", 32'(bus.col_mid), 32'(e.mid));
        chk("col_bot", 32'(bus.col_bot), 32'(e.bot));
        chk("col_x",   32'(bus.col_x),   32'(e.x));
        chk("col_y",   32'(bus.col_y),   32'(e.y));
        chk("latency", 32'(cyc),         32'(e.due));
      end
    end
  end

  initial begin
    errors        = 0;
    checks        = 0;
    col_cnt       = 0;
    reset         = 1'b0;
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_rgb   = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.col_valid), 0);
    chk("rst_x",     32'(bus.col_x),     0);
    chk("rst_y",     32'(bus.col_y),     0);
    reset = 1'b1;

    // Gray frame: first column is (0,10,20) at x=0, y=1; 16 columns total.
    col_cnt = 0;
    run_frame(0, H * V, 0, 1'b1);
    drain();
    chk("frame_cols", 32'(col_cnt), 16);
    chk("hold_valid", 32'(bus.col_valid), 0);
    chk("hold_top",   32'(bus.col_top), 10);
    chk("hold_mid",   32'(bus.col_mid), 20);
    chk("hold_bot",   32'(bus.col_bot), 30);
    chk("hold_x",     32'(bus.col_x),   7);
    chk("hold_y",     32'(bus.col_y),   2);

    // Known colours on line 2 exercise the luma coefficients.
    col_cnt = 0;
    run_frame(1, H * V, 0, 1'b1);
    drain();
    chk("luma_cols", 32'(col_cnt), 16);

    // Same gray frame with random idle cycles.
    col_cnt = 0;
    run_frame(0, H * V, 30, 1'b1);
    drain();
    chk("gap_cols", 32'(col_cnt), 16);

    // Restart: sof at line 2, x=3 directly after x=2; pipelined columns still emerge.
    col_cnt = 0;
    run_frame(0, 2 * H + 3, 0, 1'b0);
    run_frame(0, H * V, 0, 1'b1);
    drain();
    chk("restart_cols", 32'(col_cnt), 3 + 16);

    // Pixels after frame end without sof are dropped.
    col_cnt = 0;
    for (int i = 0; i < 5; i++) drive(1'b0, 24'h808080, 1'b0, sb.size() > 0 ? sb[0] : '{8'd0, 8'd0, 8'd0, 10'd0, 10'd0, 0});
    repeat (3) idle();
    chk("drop_cols", 32'(col_cnt), 0);
    chk("drop_valid", 32'(bus.col_valid), 0);
    run_frame(1, H * V, 0, 1'b1);
    drain();
    chk("after_drop_cols", 32'(col_cnt), 16);

    // Asynchronous reset in the middle of streaming line 2.
    run_frame(0, 2 * H + 5, 0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("amid_valid", 32'(bus.col_valid), 0);
    chk("amid_top",   32'(bus.col_top), 0);
    chk("amid_mid",   32'(bus.col_mid), 0);
    chk("amid_bot",   32'(bus.col_bot), 0);
    chk("amid_x",     32'(bus.col_x), 0);
    chk("amid_y",     32'(bus.col_y), 0);
    sb.delete();
    idle();
    idle();
    reset = 1'b1;
    col_cnt = 0;
    for (int i = 0; i < 4; i++) drive(1'b0, 24'h404040, 1'b0, '{8'd0, 8'd0, 8'd0, 10'd0, 10'd0, 0});
    repeat (3) idle();
    chk("post_rst_cols", 32'(col_cnt), 0);
    run_frame(0, H * V, 0, 1'b1);
    drain();
    chk("post_rst_frame", 32'(col_cnt), 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
